// File: rtl/rdout_pkg.sv
// Readout sequencer shared definitions: state encoding and
// default phase lengths for the SCA block readout.
`timescale 1ns/1ps
package rdout_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ALIGN,
      S_DATA,
      S_GAP,
      S_LAST,
      S_PAUSE,
      S_HDR,
      S_HGAP,
      S_TRL,
      S_TGAP
   } state_t;

   localparam int DEF_BLKCYC = 96;
   localparam int DEF_GAPCYC = 6;
   localparam int DEF_HDRCYC = 18;
   localparam int DEF_TRLCYC = 48;
   localparam int DEF_NBLK   = 4;

   // Phase counters are loaded with length-1 and run down to 0.
   function automatic logic [7:0] ld(input int n);
      return 8'(n - 1);
   endfunction

endpackage

// File: rtl/crc_chk_dly.sv
// CRC word enable and send-check strobe derived from the
// PUSH/XLOAD stream; XLOAD bursts never enter the pipe.
`timescale 1ns/1ps
module crc_chk_dly (
   input  logic CLK,
   input  logic RST_B,
   input  logic CLR,
   input  logic PUSH,
   input  logic XLOAD,
   output logic OECRC,
   output logic SENDCHECK
);

   logic       pre;
   logic [5:0] sp_d, sp_q;
   logic [2:0] sc_d, sc_q;

   assign pre       = PUSH & ~XLOAD;
   assign OECRC     = ~PUSH & sp_q[5];
   assign SENDCHECK = sc_q[2];

   always_comb begin
      sp_d = {sp_q[4:0], pre};
      sc_d = {sc_q[1:0], OECRC};
      if (CLR) begin
         sp_d = '0;
         sc_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         sp_q <= '0;
         sc_q <= '0;
      end else begin
         sp_q <= sp_d;
         sc_q <= sc_d;
      end
   end

endmodule

// File: rtl/rdout_seq.sv
// Event readout sequencer: NBLK data blocks with gaps, end marker,
// then header and trailer XLOAD bursts, with the CRC strobe pipe.
`timescale 1ns/1ps
module rdout_seq
   import rdout_pkg::*;
#(
   parameter int NBLK   = DEF_NBLK,
   parameter int BLKCYC = DEF_BLKCYC,
   parameter int GAPCYC = DEF_GAPCYC,
   parameter int HDRCYC = DEF_HDRCYC,
   parameter int TRLCYC = DEF_TRLCYC
) (
   input  logic CLK,
   input  logic RST_B,
   input  logic START,
   input  logic PH150,
   input  logic ABORT,
   output logic PUSH,
   output logic XLOAD,
   output logic LASTWORD,
   output logic OECRC,
   output logic SENDCHECK,
   output logic BUSY,
   output logic DONE
);

   localparam logic [7:0] L_BLK   = ld(BLKCYC);
   localparam logic [7:0] L_GAP   = ld(GAPCYC);
   localparam logic [7:0] L_GAP2  = ld(2 * GAPCYC);
   localparam logic [7:0] L_HDR   = ld(HDRCYC);
   localparam logic [7:0] L_TRL   = ld(TRLCYC);
   localparam logic [3:0] LASTBLK = 4'(NBLK - 1);

   state_t     state_d, state_q;
   logic [7:0] cnt_d, cnt_q;
   logic [3:0] blk_d, blk_q;
   logic       push_d, push_q;
   logic       xload_d, xload_q;
   logic       lw_d, lw_q;
   logic       busy_d, busy_q;
   logic       done_d, done_q;
   logic       zero;

   assign zero = (cnt_q == 8'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = zero ? 8'd0 : cnt_q - 8'd1;
      blk_d   = blk_q;
      done_d  = 1'b0;
      if (ABORT) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         blk_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE:
               if (START) state_d = S_ALIGN;
            S_ALIGN:
               if (PH150) begin
                  state_d = S_DATA;
                  cnt_d   = L_BLK;
                  blk_d   = '0;
               end
            S_DATA:
               if (zero) begin
                  state_d = (blk_q < LASTBLK) ? S_GAP : S_LAST;
                  cnt_d   = L_GAP;
               end
            S_GAP:
               if (zero) begin
                  state_d = S_DATA;
                  cnt_d   = L_BLK;
                  blk_d   = blk_q + 4'd1;
               end
            S_LAST:
               if (zero) begin
                  state_d = S_PAUSE;
                  cnt_d   = L_GAP2;
               end
            S_PAUSE:
               if (zero) begin
                  state_d = S_HDR;
                  cnt_d   = L_HDR;
               end
            S_HDR:
               if (zero) begin
                  state_d = S_HGAP;
                  cnt_d   = L_GAP2;
               end
            S_HGAP:
               if (zero) begin
                  state_d = S_TRL;
                  cnt_d   = L_TRL;
               end
            S_TRL:
               if (zero) begin
                  state_d = S_TGAP;
                  cnt_d   = L_GAP;
               end
            S_TGAP:
               if (zero) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            default:
               state_d = S_IDLE;
         endcase
      end
      // Outputs are registered decodes of the state being entered.
      push_d  = state_d inside {S_DATA, S_HDR, S_TRL};
      xload_d = state_d inside {S_HDR, S_TRL};
      lw_d    = (state_d == S_LAST);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         push_q  <= 1'b0;
         xload_q <= 1'b0;
         lw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         push_q  <= push_d;
         xload_q <= xload_d;
         lw_q    <= lw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign PUSH     = push_q;
   assign XLOAD    = xload_q;
   assign LASTWORD = lw_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

   crc_chk_dly u_crc (
      .CLK       (CLK),
      .RST_B     (RST_B),
      .CLR       (ABORT),
      .PUSH      (push_q),
      .XLOAD     (xload_q),
      .OECRC     (OECRC),
      .SENDCHECK (SENDCHECK)
   );

endmodule

// File: doc/rdout_seq.md
RDOUT_SEQ -- requirements
Module: rdout_seq

Interface
REQ-001 Parameter NBLK, default 4, number of SCA data blocks per event (1..15).
REQ-002 Parameter BLKCYC, default 96, PUSH-high cycles per data block (16 samples x 6 ADCs).
REQ-003 Parameter GAPCYC, default 6, cycles per inter-block gap (one 150 ns period).
REQ-004 Parameter HDRCYC, default 18, cycles of first XLOAD burst.
REQ-005 Parameter TRLCYC, default 48, cycles of second XLOAD burst.
REQ-006 CLK  in  1  25 ns system clock; all logic on rising edge.
REQ-007 RST_B  in  1  reset, asynchronous, active-low.
REQ-008 START  in  1  level; request readout of one event.
REQ-009 PH150  in  1  one-cycle strobe, every 6th CLK, marking the 150 ns ADC phase.
REQ-010 ABORT  in  1  synchronous abort of the current event.
REQ-011 PUSH  out  1  drives blkcpld PUSH and blkmux START.
REQ-012 XLOAD  out  1  drives blkcpld XLOAD and blkmux DLOAD.
REQ-013 LASTWORD  out  1  end-of-data marker to blkcpld.
REQ-014 OECRC  out  1  CRC word output enable to blkmux.
REQ-015 SENDCHECK  out  1  CRC send strobe to blkcpld.
REQ-016 BUSY  out  1  high from accepted START until DONE.
REQ-017 DONE  out  1  one-cycle pulse at event completion.

Function
REQ-018 States: IDLE, ALIGN, DATA, GAP, LAST, PAUSE, HDR, HGAP, TRL, TGAP; PUSH, XLOAD, LASTWORD, BUSY and DONE are registered outputs.
REQ-019 IDLE: START=1 -> ALIGN, BUSY=1 next cycle; START=0 -> remain.
REQ-020 ALIGN: wait for PH150=1; the following cycle enter DATA; blocks counter = 0.
REQ-021 DATA: PUSH=1, XLOAD=0 exactly BLKCYC cycles; then GAP if blocks done < NBLK-1, else LAST.
REQ-022 GAP: PUSH=0 exactly GAPCYC cycles, block counter increments, then DATA.
REQ-023 LAST: PUSH=0, LASTWORD=1 exactly GAPCYC cycles, then PAUSE (PUSH=0, 2*GAPCYC cycles).
REQ-024 HDR: PUSH=XLOAD=1 HDRCYC cycles; HGAP: both 0 for 2*GAPCYC cycles; TRL: PUSH=XLOAD=1 TRLCYC cycles; TGAP: both 0 for GAPCYC cycles.
REQ-025 End of TGAP: DONE=1 for one cycle, BUSY=0 the same cycle, state IDLE; START still high starts a new event (ALIGN) the next cycle.
REQ-026 START changes while BUSY=1 are ignored.
REQ-027 Cycle counter 8 bits, loaded with phase length minus 1 and counting to 0; parameter values above 256 are illegal.
REQ-028 CRC pipe: PRE = PUSH & ~XLOAD; 6-stage shift register SP of PRE; OECRC = ~PUSH & SP[5] (combinational from registers).
REQ-029 SENDCHECK = OECRC delayed 3 cycles (3-stage shift register).
REQ-030 If PUSH falls at cycle t after a data block: OECRC = 1 in cycles t..t+5; SENDCHECK = 1 in cycles t+3..t+8.
REQ-031 XLOAD bursts never raise OECRC or SENDCHECK.
REQ-032 ABORT=1 in any state: next cycle IDLE; PUSH, XLOAD, LASTWORD and BUSY = 0; both shift registers cleared; no DONE pulse.
REQ-033 ABORT has priority over START in the same cycle.

Reset
REQ-034 RST_B=0 asynchronously forces IDLE, clears counters and both shift registers, and sets every output to 0.
REQ-035 Reset deasserted mid-event: block returns to IDLE and waits for a new START with no partial sequence resumed.

Structure
REQ-036 Package rdout_pkg holds state encoding and default cycle-count constants (96, 6, 18, 48, 4).
REQ-037 Sub-module crc_chk_dly implements REQ-028..REQ-031 (inputs CLK, RST_B, CLR, PUSH, XLOAD; outputs OECRC, SENDCHECK).

Verification
REQ-038 START at cycle 0, PH150 at cycle 3 -> PUSH rises at cycle 4 and is high for 96 cycles, four times with 6-cycle gaps; LASTWORD high 6 cycles; XLOAD bursts of 18 and 48 cycles; single DONE.
REQ-039 First data block ends with PUSH falling at cycle t -> OECRC high t..t+5, SENDCHECK high t+3..t+8, repeated after each of the 4 blocks; none after the XLOAD bursts.
REQ-040 START held high through DONE -> next ALIGN begins the cycle after DONE, BUSY low exactly one cycle.
REQ-041 ABORT pulsed mid-DATA block 2 -> all outputs 0 the next cycle, OECRC and SENDCHECK stay 0, no DONE.
REQ-042 RST_B low for 1 ns during HDR -> outputs 0 immediately; after release, IDLE until START.
REQ-043 NBLK=1, BLKCYC=12 -> one 12-cycle PUSH, then LASTWORD immediately, then the header and trailer bursts.
